// File: rtl/stopwatch_pkg.sv
// Shared types for the BCD stopwatch controller.
// State encoding, digit type and digit limit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    LAP
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 counter digit of the stopwatch chain.
// Increments on inc, wraps 9 -> 0, flags when it sits at 9.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic at_max
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == BCD_MAX) ? '0 : value + 4'd1;
    end
  end

  assign at_max = (value == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch over a chain of BCD digits.
// Prescaled tick, ripple carry, lap latch, sticky overflow.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                frozen,
  output logic                overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_t              state;
  state_t              state_nx;
  logic [PW-1:0]       psc;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] latch;
  logic [DIGITS-1:0]   inc;
  logic [DIGITS-1:0]   at_max;
  logic                active;
  logic                tick;
  logic                load;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // clear > start_stop > lap
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (clear)           state_nx = IDLE;
        else if (start_stop) state_nx = RUN;
      end
      RUN: begin
        if (clear)           state_nx = RUN;
        else if (start_stop) state_nx = PAUSED;
        else if (lap)        state_nx = LAP;
      end
      LAP: begin
        if (clear)           state_nx = RUN;
        else if (start_stop) state_nx = PAUSED;
        else if (lap)        state_nx = RUN;
      end
      PAUSED: begin
        if (clear)           state_nx = IDLE;
        else if (start_stop) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN) || (state == LAP);
    frozen  = (state == LAP);
    digits  = (state == LAP) ? latch : count;
  end

  assign active = (state == RUN) || (state == LAP);
  assign tick   = active && (psc == PMAX);
  assign load   = (state == RUN) && lap
                  && !clear && !start_stop;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else if (active) begin
      psc <= psc + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      overflow <= 1'b0;
    end else if (tick && (&at_max)) begin
      overflow <= 1'b1;
    end
  end

  // latch sees the pre-increment count
  always_ff @(posedge clock) begin
    if (reset) begin
      latch <= '0;
    end else if (load) begin
      latch <= count;
    end
  end

  always_comb begin
    logic c;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      c = tick && !clear;
      for (int j = 0; j < i; j++) begin
        c = c && at_max[j];
      end
      inc[i] = c;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clock  (clock),
      .reset  (reset),
      .clr    (clear),
      .inc    (inc[g]),
      .value  (count[4*g +: 4]),
      .at_max (at_max[g])
    );
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two configurations, a decimal
// reference model, directed literals and random command pulses.
module tb_stopwatch_ctrl;

  localparam int DA = 4;
  localparam int TA = 10;
  localparam int DB = 2;
  localparam int TB = 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic clock = 1'b0;
  logic rst_a = 1'b1;
  logic ss_a  = 1'b0;
  logic cl_a  = 1'b0;
  logic lp_a  = 1'b0;
  logic rst_b = 1'b1;
  logic ss_b  = 1'b0;
  logic cl_b  = 1'b0;
  logic lp_b  = 1'b0;

  logic [4*DA-1:0] dig_a;
  logic            run_a;
  logic            frz_a;
  logic            ovf_a;
  logic [4*DB-1:0] dig_b;
  logic            run_b;
  logic            frz_b;
  logic            ovf_b;

  int checks = 0;
  int errors = 0;

  int nd [2] = '{DA, DB};
  int td [2] = '{TA, TB};
  int m_mode [2];
  int m_cnt  [2];
  int m_psc  [2];
  int m_lat  [2];
  bit m_ovf  [2];
  bit armed  [2] = '{1'b0, 1'b0};

  stopwatch_ctrl #(.DIGITS(DA), .TICK_DIV(TA)) u_a (
    .clock      (clock),
    .reset      (rst_a),
    .start_stop (ss_a),
    .clear      (cl_a),
    .lap        (lp_a),
    .digits     (dig_a),
    .running    (run_a),
    .frozen     (frz_a),
    .overflow   (ovf_a)
  );

  stopwatch_ctrl #(.DIGITS(DB), .TICK_DIV(TB)) u_b (
    .clock      (clock),
    .reset      (rst_b),
    .start_stop (ss_b),
    .clear      (cl_b),
    .lap        (lp_b),
    .digits     (dig_b),
    .running    (run_b),
    .frozen     (frz_b),
    .overflow   (ovf_b)
  );

  initial forever #5 clock = ~clock;

  function automatic int lim(int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] to_bcd(int v, int d);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_disp(int k);
    return to_bcd((m_mode[k] == M_LAP) ? m_lat[k] : m_cnt[k], nd[k]);
  endfunction

  // Reference: count kept as a plain decimal integer
  task automatic mstep(int k, bit r, bit ss, bit cl, bit lp);
    bit act;
    bit tk;
    int old;
    if (r) begin
      m_mode[k] = M_IDLE;
      m_cnt[k]  = 0;
      m_psc[k]  = 0;
      m_lat[k]  = 0;
      m_ovf[k]  = 1'b0;
      armed[k]  = 1'b1;
      return;
    end
    act = (m_mode[k] == M_RUN) || (m_mode[k] == M_LAP);
    tk  = act && (m_psc[k] == td[k] - 1);
    old = m_cnt[k];
    if (cl) begin
      m_cnt[k]  = 0;
      m_psc[k]  = 0;
      m_ovf[k]  = 1'b0;
      m_mode[k] = act ? M_RUN : M_IDLE;
    end else begin
      if (tk) m_psc[k] = 0;
      else if (act) m_psc[k] = m_psc[k] + 1;
      if (tk) begin
        if (old + 1 == lim(nd[k])) begin
          m_cnt[k] = 0;
          m_ovf[k] = 1'b1;
        end else begin
          m_cnt[k] = old + 1;
        end
      end
      if (ss) begin
        m_mode[k] = act ? M_PAUSE : M_RUN;
      end else if (lp) begin
        if (m_mode[k] == M_RUN) begin
          m_mode[k] = M_LAP;
          m_lat[k]  = old;
        end else if (m_mode[k] == M_LAP) begin
          m_mode[k] = M_RUN;
        end
      end
    end
  endtask

  always @(posedge clock) begin
    mstep(0, rst_a, ss_a, cl_a, lp_a);
    mstep(1, rst_b, ss_b, cl_b, lp_b);
  end

  task automatic chkv(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, logic [31:0] d, logic r, logic f, logic o);
    string p;
    p = (k == 0) ? "a" : "b";
    chkv({p, " digits"}, d, m_disp(k));
    chkv({p, " running"}, 32'(r),
         32'((m_mode[k] == M_RUN) || (m_mode[k] == M_LAP)));
    chkv({p, " frozen"}, 32'(f), 32'(m_mode[k] == M_LAP));
    chkv({p, " overflow"}, 32'(o), 32'(m_ovf[k]));
  endtask

  always @(negedge clock) begin
    if (armed[0]) cmp(0, 32'(dig_a), run_a, frz_a, ovf_a);
    if (armed[1]) cmp(1, 32'(dig_b), run_b, frz_b, ovf_b);
  end

  // Literal pins: both DUT and model must show the hand value
  task automatic lit(string nm, int k, logic [31:0] exp);
    logic [31:0] act;
    act = (k == 0) ? 32'(dig_a) : 32'(dig_b);
    chkv({nm, " dut"}, act, exp);
    chkv({nm, " model"}, m_disp(k), exp);
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    cyc(2);
    rst_a = 1'b0;
    rst_b = 1'b0;
    lit("a reset", 0, 32'h0);
    lit("b reset", 1, 32'h0);
    chkv("b reset running", 32'(run_b), 32'h0);
    chkv("b reset overflow", 32'(ovf_b), 32'h0);

    ss_b = 1'b1; cyc(1); ss_b = 1'b0;
    cyc(10);
    lit("b carry 10", 1, 32'h10);
    cyc(89);
    lit("b at 99", 1, 32'h99);
    chkv("b no ovf at 99", 32'(ovf_b), 32'h0);
    cyc(1);
    lit("b wrap", 1, 32'h00);
    chkv("b ovf set", 32'(ovf_b), 32'h1);

    ss_b = 1'b1; cyc(1); ss_b = 1'b0;
    lit("b pause after wrap", 1, 32'h01);
    cl_b = 1'b1; cyc(1); cl_b = 1'b0;
    lit("b paused clear", 1, 32'h00);
    chkv("b ovf cleared", 32'(ovf_b), 32'h0);
    chkv("b idle running", 32'(run_b), 32'h0);
    lp_b = 1'b1; cyc(1); lp_b = 1'b0;
    chkv("b idle lap frozen", 32'(frz_b), 32'h0);
    chkv("b idle lap running", 32'(run_b), 32'h0);

    ss_b = 1'b1; cyc(1); ss_b = 1'b0;
    cyc(17);
    lit("b at 17", 1, 32'h17);
    cl_b = 1'b1; ss_b = 1'b1; cyc(1); cl_b = 1'b0; ss_b = 1'b0;
    lit("b clear beats ss", 1, 32'h00);
    chkv("b still running", 32'(run_b), 32'h1);

    cyc(23);
    lit("b live 23", 1, 32'h23);
    lp_b = 1'b1; cyc(1); lp_b = 1'b0;
    lit("b lap hold", 1, 32'h23);
    chkv("b frozen", 32'(frz_b), 32'h1);
    cyc(3);
    lit("b lap still", 1, 32'h23);
    cyc(2);
    lp_b = 1'b1; cyc(1); lp_b = 1'b0;
    lit("b lap release", 1, 32'h30);
    chkv("b released", 32'(frz_b), 32'h0);

    cl_b = 1'b1; cyc(1); cl_b = 1'b0;
    cyc(9);
    lit("b at 09", 1, 32'h09);
    ss_b = 1'b1; cyc(1); ss_b = 1'b0;
    lit("b tick collision", 1, 32'h10);
    chkv("b collision paused", 32'(run_b), 32'h0);
    cyc(3);
    lit("b pause hold", 1, 32'h10);

    cl_b = 1'b1; cyc(1); cl_b = 1'b0;
    ss_b = 1'b1; cyc(1); ss_b = 1'b0;
    cyc(42);
    lit("b at 42", 1, 32'h42);
    rst_b = 1'b1; cyc(1);
    lit("b midrun reset", 1, 32'h00);
    chkv("b reset run", 32'(run_b), 32'h0);
    chkv("b reset frz", 32'(frz_b), 32'h0);
    cyc(1); rst_b = 1'b0;

    ss_a = 1'b1; cyc(1); ss_a = 1'b0;
    cyc(50);
    lit("a 50 cycles", 0, 32'h0005);
    cyc(4);
    ss_a = 1'b1; cyc(1); ss_a = 1'b0;
    cyc(30);
    lit("a pause hold", 0, 32'h0005);
    chkv("a paused", 32'(run_a), 32'h0);
    ss_a = 1'b1; cyc(1); ss_a = 1'b0;
    cyc(4);
    lit("a before resume tick", 0, 32'h0005);
    cyc(1);
    lit("a resume tick", 0, 32'h0006);

    for (int n = 0; n < 3000; n++) begin
      rst_a = ($urandom_range(499) == 0);
      ss_a  = ($urandom_range(19) == 0);
      cl_a  = ($urandom_range(59) == 0);
      lp_a  = ($urandom_range(14) == 0);
      rst_b = ($urandom_range(499) == 0);
      ss_b  = ($urandom_range(19) == 0);
      cl_b  = ($urandom_range(59) == 0);
      lp_b  = ($urandom_range(14) == 0);
      cyc(1);
    end
    {rst_a, ss_a, cl_a, lp_a} = '0;
    {rst_b, ss_b, cl_b, lp_b} = '0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
